// File: rtl/pheap_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pheap_arbiter
//  Description : Round-robin sharing of one pheap event queue among PDES cores;
//                sequences enq/deq pulses and returns dequeued events.
//  Revision    : 1.0 - initial release
// ============================================================================
module pheap_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int DWIDTH    = 32,
    parameter int CIDW      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CORES-1:0]        req_valid,
    input  logic [NUM_CORES-1:0]        req_op,
    input  logic [NUM_CORES*DWIDTH-1:0] req_data,
    output logic [NUM_CORES-1:0]        req_ack,
    output logic                        rsp_valid,
    output logic [CIDW-1:0]             rsp_core,
    output logic [DWIDTH-1:0]           rsp_data,
    output logic                        rsp_nodata,
    output logic                        pq_enq,
    output logic                        pq_deq,
    output logic [DWIDTH-1:0]           pq_inp_data,
    input  logic [DWIDTH-1:0]           pq_out_data,
    input  logic                        pq_full,
    input  logic                        pq_empty,
    input  logic                        pq_ready,
    output logic [31:0]                 stat_enq,
    output logic [31:0]                 stat_deq
);

    localparam logic [1:0]    c_ST_IDLE  = 2'd0;
    localparam logic [1:0]    c_ST_ISSUE = 2'd1;
    localparam logic [1:0]    c_ST_WAIT  = 2'd2;
    localparam logic [CIDW:0] c_NUM      = (CIDW+1)'(NUM_CORES);

    logic [1:0]           r_state, w_state_nxt;
    logic [CIDW-1:0]      r_rr, r_id, w_pick, w_rr_nxt;
    logic                 r_op, r_nodata;
    logic [NUM_CORES-1:0] w_elig;
    logic                 w_found, w_grant, w_sel_op;
    logic [CIDW:0]        w_dist, w_best, w_inc;
    logic [DWIDTH-1:0]    w_sel_data;

    logic [NUM_CORES-1:0] r_req_ack;
    logic                 r_rsp_valid, r_rsp_nodata, r_pq_enq, r_pq_deq;
    logic [CIDW-1:0]      r_rsp_core;
    logic [DWIDTH-1:0]    r_rsp_data, r_pq_inp_data;
    logic [31:0]          r_stat_enq, r_stat_deq;

    // A dequeue never needs heap space, so only enqueues are blocked by full.
    assign w_elig = req_valid & (req_op | {NUM_CORES{~pq_full}});

    // Winner is the eligible core with the smallest wrapped distance from r_rr.
    always_comb begin
        w_found    = 1'b0;
        w_pick     = '0;
        w_best     = c_NUM;
        w_dist     = '0;
        w_sel_data = '0;
        w_sel_op   = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            w_dist = (CIDW+1)'(i) + c_NUM - {1'b0, r_rr};
            if (w_dist >= c_NUM) w_dist = w_dist - c_NUM;
            if (w_elig[i] && (w_dist < w_best)) begin
                w_found    = 1'b1;
                w_best     = w_dist;
                w_pick     = CIDW'(i);
                w_sel_data = req_data[i*DWIDTH +: DWIDTH];
                w_sel_op   = req_op[i];
            end
        end
    end

    assign w_grant = (r_state == c_ST_IDLE) && pq_ready && w_found;

    always_comb begin
        w_inc    = {1'b0, r_id} + (CIDW+1)'(1);
        w_rr_nxt = (w_inc >= c_NUM) ? '0 : w_inc[CIDW-1:0];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_grant) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (pq_ready) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Pulses are launched on the IDLE->ISSUE edge so they are seen during ISSUE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr          <= '0;
            r_id          <= '0;
            r_op          <= 1'b0;
            r_nodata      <= 1'b0;
            r_req_ack     <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_core    <= '0;
            r_rsp_data    <= '0;
            r_rsp_nodata  <= 1'b0;
            r_pq_enq      <= 1'b0;
            r_pq_deq      <= 1'b0;
            r_pq_inp_data <= '0;
            r_stat_enq    <= '0;
            r_stat_deq    <= '0;
        end else begin
            r_req_ack   <= '0;
            r_pq_enq    <= 1'b0;
            r_pq_deq    <= 1'b0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant) begin
                        r_id      <= w_pick;
                        r_op      <= w_sel_op;
                        r_nodata  <= w_sel_op & pq_empty;
                        r_req_ack <= NUM_CORES'(1) << w_pick;
                        if (!w_sel_op) begin
                            r_pq_enq      <= 1'b1;
                            r_pq_inp_data <= w_sel_data;
                        end else if (!pq_empty) begin
                            r_pq_deq <= 1'b1;
                        end
                    end
                end
                c_ST_ISSUE: begin
                    r_rr <= w_rr_nxt;
                    if (!r_op) begin
                        r_stat_enq <= r_stat_enq + 32'd1;
                    end else begin
                        r_rsp_valid  <= 1'b1;
                        r_rsp_core   <= r_id;
                        r_rsp_nodata <= r_nodata;
                        r_rsp_data   <= r_nodata ? '0 : pq_out_data;
                        if (!r_nodata) r_stat_deq <= r_stat_deq + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ack     = r_req_ack;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_core    = r_rsp_core;
    assign rsp_data    = r_rsp_data;
    assign rsp_nodata  = r_rsp_nodata;
    assign pq_enq      = r_pq_enq;
    assign pq_deq      = r_pq_deq;
    assign pq_inp_data = r_pq_inp_data;
    assign stat_enq    = r_stat_enq;
    assign stat_deq    = r_stat_deq;

endmodule
`default_nettype wire
